adc_trig_capture: RTL and testbench

- Downstream consumer of the deserialised ADC sample words produced on the divided data clock; one instance per monitored channel.
- Captures a fixed-length window of samples around a rising level-crossing trigger into an internal circular buffer. Pre-trigger history is retained.
- Replays the captured window oldest-first over a valid/ready stream to the readout/host logic.

---
 rtl/adc_trig_capture.sv | 145 ++++++++++++++
 tb/tb_adc_trig_capture.sv | 139 +++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// Trigger-windowed capture of one ADC channel into a circular buffer, replayed oldest-first.
// Optional CAP_TSTAMP_EN prepends a 32-bit sample-count timestamp as two header words.
module adc_trig_capture #(
  parameter int AW  = 10,
  parameter int PRE = 256,
  parameter int DW  = 16
) (
  input  logic          CLKDIV,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] thresh,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          triggered
);
  localparam int DEPTH = 1 << AW;
`ifdef CAP_TSTAMP_EN
  localparam int NW = DEPTH + 2;
`else
  localparam int NW = DEPTH;
`endif
  localparam logic [AW:0]   PRE_END   = (AW+1)'(PRE - 1);
  localparam logic [AW:0]   POST_LAST = (AW+1)'(DEPTH - PRE - 1);
  localparam logic [AW-1:0] PRE_A     = AW'(PRE);
  localparam logic [AW+1:0] NW_C      = (AW+2)'(NW);

  typedef enum logic [2:0] {IDLE, FILL, WAIT, POST, READ} state_t;
  state_t state, state_nx;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, trig_addr, rd_addr;
  logic [DW-1:0] thr_q, prev;
  logic [AW:0]   pre_cnt, post_cnt;
  logic [AW+1:0] rd_cnt;
  logic          force_pend, trig_hit, we, rd_en, xfer;
  logic          hdr_sel;
  logic [DW-1:0] hdr_word;

  assign xfer = m_valid && m_ready;

  always_ff @(posedge CLKDIV or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (arm) state_nx = FILL;
      FILL: if (din_vld && pre_cnt == PRE_END) state_nx = WAIT;
      WAIT: if (trig_hit) state_nx = (POST_LAST == '0) ? READ : POST;
      POST: if (din_vld && post_cnt == POST_LAST) state_nx = READ;
      READ: if (xfer && m_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    we       = din_vld && (state == FILL || state == WAIT || state == POST);
    // A pending software trigger fires on the next valid sample.
    trig_hit = (state == WAIT) && din_vld &&
               (((prev < thr_q) && (din >= thr_q)) || force_trig || force_pend);
    rd_en    = (state == READ) && (rd_cnt != NW_C) && (!m_valid || m_ready);
  end

`ifdef CAP_TSTAMP_EN
  logic [31:0] ts_cnt, ts_q;
  always_ff @(posedge CLKDIV or posedge rst)
    if (rst) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      if (din_vld)  ts_cnt <= ts_cnt + 32'd1;
      if (trig_hit) ts_q   <= ts_cnt;
    end
  assign hdr_sel  = (rd_cnt < (AW+2)'(2));
  assign hdr_word = (rd_cnt == '0) ? DW'(ts_q[31:16]) : DW'(ts_q[15:0]);
`else
  assign hdr_sel  = 1'b0;
  assign hdr_word = '0;
`endif

  always_ff @(posedge CLKDIV)
    if (we) mem[wp] <= din;

  always_ff @(posedge CLKDIV or posedge rst)
    if (rst) begin
      wp         <= '0;
      trig_addr  <= '0;
      rd_addr    <= '0;
      thr_q      <= '0;
      prev       <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      force_pend <= 1'b0;
      triggered  <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      if (state == IDLE && arm) begin
        thr_q   <= thresh;
        pre_cnt <= '0;
      end
      if (we) begin
        wp   <= wp + 1'b1;
        prev <= din;
      end
      if (state == FILL && din_vld) pre_cnt <= pre_cnt + 1'b1;
      if (state == WAIT) force_pend <= (force_pend || force_trig) && !trig_hit;
      else               force_pend <= 1'b0;
      if (trig_hit) begin
        triggered <= 1'b1;
        trig_addr <= wp;
        post_cnt  <= (AW+1)'(1);
      end
      if (state == POST && din_vld) post_cnt <= post_cnt + 1'b1;
      // Oldest sample sits PRE slots behind the trigger sample.
      if (state != READ && state_nx == READ) begin
        rd_addr <= (trig_hit ? wp : trig_addr) - PRE_A;
        rd_cnt  <= '0;
      end
      if (rd_en) begin
        m_valid <= 1'b1;
        m_last  <= (rd_cnt == NW_C - 1'b1);
        rd_cnt  <= rd_cnt + 1'b1;
        if (hdr_sel) m_data <= hdr_word;
        else begin
          m_data  <= mem[rd_addr];
          rd_addr <= rd_addr + 1'b1;
        end
      end else if (xfer) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (state == READ && xfer && m_last) triggered <= 1'b0;
    end
endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture at AW=4, PRE=4: ramp captures, gapped input, force trigger, stalls, reset abort.
module tb_adc_trig_capture;
  localparam int AW = 4, PRE = 4, DW = 16, DEPTH = 16;
`ifdef CAP_TSTAMP_EN
  localparam int NW = DEPTH + 2;
`else
  localparam int NW = DEPTH;
`endif

  logic          CLKDIV = 1'b0, rst = 1'b1;
  logic [DW-1:0] din = '0, thresh = '0, m_data;
  logic          din_vld = 1'b0, arm = 1'b0, force_trig = 1'b0, m_ready = 1'b0;
  logic          m_valid, m_last, busy, triggered;

  int n_tests = 0, n_fail = 0;
  logic [31:0] vcnt, ts_exp = '0;

  adc_trig_capture #(.AW(AW), .PRE(PRE), .DW(DW)) dut (
    .CLKDIV(CLKDIV), .rst(rst), .din(din), .din_vld(din_vld), .arm(arm),
    .force_trig(force_trig), .thresh(thresh), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .triggered(triggered)
  );

  always #5 CLKDIV = ~CLKDIV;

  // Count of valid samples since reset, for the expected timestamp.
  always @(posedge CLKDIV or posedge rst)
    if (rst) vcnt <= '0;
    else if (din_vld) vcnt <= vcnt + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int k, input int first);
`ifdef CAP_TSTAMP_EN
    if (k == 0) return ts_exp[31:16];
    if (k == 1) return ts_exp[15:0];
    return 16'(first + k - 2);
`else
    return 16'(first + k);
`endif
  endfunction

  task automatic capture(input logic [15:0] th, input int trig_v, input int force_v,
                         input bit tog, input int stop_v);
    int v;
    bit ph;
    @(negedge CLKDIV); arm = 1'b1; thresh = th;
    @(negedge CLKDIV); arm = 1'b0;
    v = 0; ph = 1'b0;
    while (v <= stop_v) begin
      if (v == force_v && !(tog && ph)) begin
        chk("wait_no_trig", {31'd0, triggered}, 32'd0);
        chk("wait_busy", {31'd0, busy}, 32'd1);
      end
      if (tog && ph) begin
        din_vld = 1'b0; din = 16'hbeef; force_trig = 1'b0;
      end else begin
        din_vld = 1'b1; din = v[15:0]; force_trig = (v == force_v);
        if (v == trig_v) ts_exp = vcnt;
        v++;
      end
      ph = !ph;
      @(negedge CLKDIV);
    end
    din_vld = 1'b0; force_trig = 1'b0; din = '0;
  endtask

  task automatic readout(input int first, input bit stall);
    int got, cyc, ph;
    bit rdy;
    got = 0; cyc = 0; ph = 0;
    chk("trig_in_read", {31'd0, triggered}, 32'd1);
    while (got < NW && cyc < 300) begin
      rdy = stall ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
      ph++;
      m_ready = rdy;
      if (m_valid) begin
        chk("m_data", {16'd0, m_data}, {16'd0, exp_word(got, first)});
        if (rdy) begin
          chk("m_last", {31'd0, m_last}, {31'd0, (got == NW - 1)});
          got++;
        end
      end
      @(negedge CLKDIV);
      cyc++;
    end
    m_ready = 1'b0;
    chk("rd_count", got, NW);
    chk("post_valid", {31'd0, m_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_trig", {31'd0, triggered}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLKDIV);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_trig", {31'd0, triggered}, 32'd0);
    chk("rst_data", {16'd0, m_data}, 32'd0);
    rst = 1'b0;

    // Level crossing at 10: window 6..21
    capture(16'd10, 10, -1, 1'b0, 21);
    readout(6, 1'b0);

    // Gapped input yields the same window
    capture(16'd10, 10, -1, 1'b1, 21);
    readout(6, 1'b0);

    // Crossing falls inside FILL; only the software trigger at 20 fires
    capture(16'd3, 20, 20, 1'b0, 31);
    readout(16, 1'b0);

    // Back-pressure 1,0,0,1
    capture(16'd10, 10, -1, 1'b0, 21);
    readout(6, 1'b1);

    // Abort in POST, then a fresh capture
    capture(16'd10, 10, -1, 1'b0, 13);
    rst = 1'b1;
    @(negedge CLKDIV);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_trig", {31'd0, triggered}, 32'd0);
    rst = 1'b0;
    capture(16'd10, 10, -1, 1'b0, 21);
    readout(6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
